// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a single 32-bit barrel shifter. Accepts one request
// at a time, shifts the registered operands and returns a tagged result.
module barrelshifter32 (
  input  logic [31:0] i_a,
  input  logic [4:0]  i_b,
  input  logic [1:0]  i_aluc,
  output logic [31:0] o_c
);
  // aluc: 00 SRA, 10 SRL, x1 SLL
  always_comb begin
    o_c = 32'd0;
    if (i_aluc[0])      o_c = i_a << i_b;
    else if (i_aluc[1]) o_c = i_a >> i_b;
    else                o_c = $unsigned($signed(i_a) >>> i_b);
  end
endmodule

module shift_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_b,
  input  logic [1:0]       req0_aluc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_b,
  input  logic [1:0]       req1_aluc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and payload steady until that edge.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       r_state;
  logic             r_last;
  logic [31:0]      r_a;
  logic [4:0]       r_b;
  logic [1:0]       r_aluc;
  logic             r_id;
  logic             r_res_valid;
  logic [31:0]      r_res_data;
  logic             r_res_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [31:0]      w_shift;

  // On a tie, round-robin favours the port not granted last time
  always_comb begin
    w_grant = 1'b0;
    if (req1_valid && !req0_valid)     w_grant = 1'b1;
    else if (req0_valid && req1_valid) w_grant = RR_EN ? ~r_last : 1'b0;
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_accept   = req0_ready || req1_ready;

  barrelshifter32 u_shifter (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_aluc (r_aluc),
    .o_c    (w_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_a         <= 32'd0;
      r_b         <= 5'd0;
      r_aluc      <= 2'd0;
      r_id        <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'd0;
      r_res_id    <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant ? req1_a    : req0_a;
            r_b     <= w_grant ? req1_b    : req0_b;
            r_aluc  <= w_grant ? req1_aluc : req0_aluc;
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_res_data  <= w_shift;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = !w_idle;
  assign op_count  = r_op_count;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin instance (CNT_W=16) and a fixed-priority
// instance (CNT_W=2) share all inputs and run in lockstep.
module tb_shift_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, res_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_b, req1_b;
  logic [1:0]  req0_aluc, req1_aluc;

  logic        d_req0_ready, d_req1_ready, d_res_valid, d_res_id, d_busy;
  logic [31:0] d_res_data;
  logic [15:0] d_op_count;
  logic [1:0]  d_dbg_state;
  logic        f_req0_ready, f_req1_ready, f_res_valid, f_res_id, f_busy;
  logic [31:0] f_res_data;
  logic [1:0]  f_op_count;
  logic [1:0]  f_dbg_state;

  shift_arbiter #(.RR_EN(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(d_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(d_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .res_valid(d_res_valid), .res_ready(res_ready), .res_data(d_res_data), .res_id(d_res_id),
    .busy(d_busy), .op_count(d_op_count), .dbg_state(d_dbg_state)
  );

  shift_arbiter #(.RR_EN(1'b0), .CNT_W(2)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .res_valid(f_res_valid), .res_ready(res_ready), .res_data(f_res_data), .res_id(f_res_id),
    .busy(f_busy), .op_count(f_op_count), .dbg_state(f_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_dut   = 0;
  int n_fp    = 0;
  logic [32:0] exp_dut_q[$];
  logic [32:0] exp_fp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected {id,data} per result handoff
  always @(negedge clk) begin
    if (!rst && res_ready) begin
      if (d_res_valid) begin
        if (exp_dut_q.size() == 0) check("dut_unexpected_result", {31'd0, d_res_id, d_res_data}, 64'd0);
        else check("dut_result", {31'd0, d_res_id, d_res_data}, {31'd0, exp_dut_q.pop_front()});
      end
      if (f_res_valid) begin
        if (exp_fp_q.size() == 0) check("fp_unexpected_result", {31'd0, f_res_id, f_res_data}, 64'd0);
        else check("fp_result", {31'd0, f_res_id, f_res_data}, {31'd0, exp_fp_q.pop_front()});
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    #1;
    while (!(d_req0_ready || d_req1_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    ok = (t < 20);
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(
    input logic v0, input logic [31:0] a0, input logic [4:0] b0, input logic [1:0] c0,
    input logic v1, input logic [31:0] a1, input logic [4:0] b1, input logic [1:0] c1,
    input logic [32:0] e_dut, input logic [32:0] e_fp, input int hold
  );
    bit ok;
    int t;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_aluc = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_aluc = c1;
    exp_dut_q.push_back(e_dut);
    exp_fp_q.push_back(e_fp);
    wait_ready(ok);
    if (!ok) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check("dut_grant", {62'd0, d_req1_ready, d_req0_ready}, e_dut[32] ? 64'd2 : 64'd1);
    check("fp_grant",  {62'd0, f_req1_ready, f_req0_ready}, e_fp[32]  ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    // Disturb the inputs: the in-flight op must ignore them
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req1_a = ~req1_a; req0_b = req0_b + 5'd3; req1_b = req1_b + 5'd3;
    res_ready = (hold == 0);
    check("latency_shift", {62'd0, d_busy, d_res_valid}, 64'd2);
    @(posedge clk); #1;
    check("latency_valid", {62'd0, d_res_valid, f_res_valid}, 64'd3);
    if (hold > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_stable", {15'd0, d_res_valid, d_res_id, d_res_data, d_op_count},
              {15'd0, 1'b1, e_dut[32], e_dut[31:0], n_dut[15:0]});
        check("hold_no_ready", {60'd0, d_req0_ready, d_req1_ready, f_req0_ready, f_req1_ready}, 64'd0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    end
    t = 0;
    while (d_busy && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) check("handoff_timeout", 64'd0, 64'd1);
    n_dut++; n_fp++;
    check("dut_op_count", {48'd0, d_op_count}, {48'd0, n_dut[15:0]});
    check("fp_op_count",  {62'd0, f_op_count}, {62'd0, n_fp[1:0]});
  endtask

  task automatic reset_in_shift();
    bit ok;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_b = 5'd1; req0_aluc = 2'b10;
    wait_ready(ok);
    if (!ok) begin
      req0_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    check("rst_pre_shift", {62'd0, d_busy, d_res_valid}, 64'd2);
    @(posedge clk); #1;
    check("rst_dut_state", {14'd0, d_busy, d_res_valid, d_res_data, d_op_count}, 64'd0);
    check("rst_fp_state",  {28'd0, f_busy, f_res_valid, f_res_data, f_op_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_dut = 0; n_fp = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_no_delivery", {62'd0, d_res_valid, f_res_valid}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut", {13'd0, d_busy, d_res_valid, d_res_id, d_res_data, d_op_count}, 64'd0);
    check("reset_fp",  {27'd0, f_busy, f_res_valid, f_res_id, f_res_data, f_op_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_no_ready", {60'd0, d_req0_ready, d_req1_ready, f_req0_ready, f_req1_ready}, 64'd0);

    // Single-requester directed vectors (op_count on CNT_W=2 goes 1,2,3,0,1)
    run_op(1'b1, 32'h8000_0000, 5'd4, 2'b00, 1'b0, 32'd0, 5'd0, 2'b00,
           {1'b0, 32'hF800_0000}, {1'b0, 32'hF800_0000}, 0);
    run_op(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, 32'h8000_0000, 5'd4, 2'b10,
           {1'b1, 32'h0800_0000}, {1'b1, 32'h0800_0000}, 0);
    run_op(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, 32'h0000_0001, 5'd31, 2'b01,
           {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000}, 0);
    run_op(1'b1, 32'h8765_4321, 5'd0, 2'b00, 1'b0, 32'd0, 5'd0, 2'b00,
           {1'b0, 32'h8765_4321}, {1'b0, 32'h8765_4321}, 0);
    run_op(1'b0, 32'd0, 5'd0, 2'b00, 1'b1, 32'h1234_5678, 5'd0, 2'b11,
           {1'b1, 32'h1234_5678}, {1'b1, 32'h1234_5678}, 0);

    // Result held with res_ready low for 5 cycles
    run_op(1'b1, 32'h0000_0003, 5'd8, 2'b01, 1'b0, 32'd0, 5'd0, 2'b00,
           {1'b0, 32'h0000_0300}, {1'b0, 32'h0000_0300}, 5);
    run_op(1'b1, 32'h7000_0000, 5'd4, 2'b00, 1'b0, 32'd0, 5'd0, 2'b00,
           {1'b0, 32'h0700_0000}, {1'b0, 32'h0700_0000}, 0);

    reset_in_shift();

    // Both ports valid: round-robin grants 0,1,0,1; fixed priority grants 0,0,0,0
    run_op(1'b1, 32'h0000_00F0, 5'd4, 2'b10, 1'b1, 32'h0000_000F, 5'd4, 2'b01,
           {1'b0, 32'h0000_000F}, {1'b0, 32'h0000_000F}, 0);
    run_op(1'b1, 32'h0000_00F0, 5'd4, 2'b10, 1'b1, 32'h0000_000F, 5'd4, 2'b01,
           {1'b1, 32'h0000_00F0}, {1'b0, 32'h0000_000F}, 0);
    run_op(1'b1, 32'h0000_00F0, 5'd4, 2'b10, 1'b1, 32'h0000_000F, 5'd4, 2'b01,
           {1'b0, 32'h0000_000F}, {1'b0, 32'h0000_000F}, 0);
    run_op(1'b1, 32'h0000_00F0, 5'd4, 2'b10, 1'b1, 32'h0000_000F, 5'd4, 2'b01,
           {1'b1, 32'h0000_00F0}, {1'b0, 32'h0000_000F}, 0);

    repeat (5) @(posedge clk);
    #1;
    check("dut_queue_drained", exp_dut_q.size(), 64'd0);
    check("fp_queue_drained",  exp_fp_q.size(),  64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
